// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: issues imem reads at the current PC, tracks reads in flight
// and buffers returned words in order for decode, discarding stale data after a redirect.
module inst_fetch_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  output logic [31:0] o_npc,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t          LAST_P  = ptr_t'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_U = (CW + 1)'(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t      r_state;
  state_t      w_stateNxt;

  cnt_t        r_outstanding;
  cnt_t        r_drop;
  cnt_t        r_count;

  logic [31:0] r_addrMem [DEPTH];
  ptr_t        r_addrWr;
  ptr_t        r_addrRd;

  logic [63:0] r_instMem [DEPTH];
  ptr_t        r_instWr;
  ptr_t        r_instRd;

  logic        w_issue;
  logic        w_grant;
  logic        w_resp;
  logic        w_enq;
  logic        w_deq;
  logic [CW:0] w_used;
  logic [31:0] w_popPc;

  function automatic ptr_t ptrInc(input ptr_t p);
    return (p == LAST_P) ? '0 : p + ptr_t'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNxt;
    end
  end

  // A fetch slot is reserved at issue, so in-flight reads plus buffered words never exceed DEPTH.
  assign w_used = {1'b0, r_outstanding} + {1'b0, r_count};

  always_comb begin
    w_stateNxt = r_state;
    w_issue    = 1'b0;
    unique case (r_state)
      ST_IDLE: w_stateNxt = ST_RUN;
      ST_RUN:  w_issue    = !i_redirect_valid && (w_used < DEPTH_U);
    endcase
  end

  assign o_imem_req  = w_issue;
  assign o_imem_addr = i_pc & ~32'd3;
  assign w_grant     = o_imem_req & i_imem_gnt;

  assign o_npc = i_redirect_valid ? (i_redirect_target & ~32'd3) :
                 w_grant          ? (i_pc + 32'd4) :
                                    i_pc;

  // Responses with nothing in flight are strays (e.g. left over from before a reset).
  assign w_resp  = i_imem_rvalid && (r_outstanding != '0);
  assign w_enq   = w_resp && !i_redirect_valid && (r_drop == '0);
  assign w_deq   = o_inst_valid && i_inst_ready;
  assign w_popPc = r_addrMem[r_addrRd];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_outstanding <= '0;
      r_addrWr      <= '0;
      r_addrRd      <= '0;
    end else begin
      r_outstanding <= r_outstanding + cnt_t'(w_grant) - cnt_t'(w_resp);
      if (w_grant) begin
        r_addrWr <= ptrInc(r_addrWr);
      end
      if (w_resp) begin
        r_addrRd <= ptrInc(r_addrRd);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_grant) begin
      r_addrMem[r_addrWr] <= i_pc;
    end
  end

  // Everything still in flight at a redirect belongs to the old path and must be dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_drop <= '0;
    end else if (i_redirect_valid) begin
      r_drop <= r_outstanding - cnt_t'(w_resp);
    end else if (w_resp && (r_drop != '0)) begin
      r_drop <= r_drop - cnt_t'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_instWr <= '0;
      r_instRd <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instMem[i] <= '0;
      end
    end else if (i_redirect_valid) begin
      r_count  <= '0;
      r_instWr <= '0;
      r_instRd <= '0;
    end else begin
      r_count <= r_count + cnt_t'(w_enq) - cnt_t'(w_deq);
      if (w_enq) begin
        r_instMem[r_instWr] <= {w_popPc, i_imem_rdata};
        r_instWr            <= ptrInc(r_instWr);
      end
      if (w_deq) begin
        r_instRd <= ptrInc(r_instRd);
      end
    end
  end

  assign o_inst_valid = (r_count != '0);
  assign o_inst_pc    = r_instMem[r_instRd][63:32];
  assign o_inst       = r_instMem[r_instRd][31:0];

endmodule
